align_ctrl: RTL and testbench

Sequencer for the ALIGN stage. Accepts a job descriptor (iteration count, reads per iteration) from the layer controller and programs ALIGN through a one-cycle configure pulse. It then counts accepted output beats per iteration and per job, and reports iteration and job completion. It sits between the top-level layer FSM and the ALIGN configure port, and observes the ALIGN output handshake.

---
 rtl/align_ctrl_pkg.sv | 15 +
 rtl/align_ctrl.sv | 98 +++++++++
 tb/tb_align_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/align_ctrl_pkg.sv
// Shared definitions for the stage sequencers: state encoding and default
// counter widths.
package align_ctrl_pkg;

  localparam int DEFAULT_LOG_MAX_ITERS          = 16;
  localparam int DEFAULT_LOG_MAX_READS_PER_ITER = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONFIG = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/align_ctrl.sv
// ALIGN stage sequencer: latches a job, pulses configure, counts accepted
// output beats per iteration and per job, and reports completion.
module align_ctrl
  import align_ctrl_pkg::*;
#(
  parameter int LOG_MAX_ITERS          = DEFAULT_LOG_MAX_ITERS,
  parameter int LOG_MAX_READS_PER_ITER = DEFAULT_LOG_MAX_READS_PER_ITER
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [LOG_MAX_ITERS-1:0]          job_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] job_reads,
  output logic                              busy,
  output logic                              configure,
  output logic [LOG_MAX_ITERS-1:0]          num_iters,
  output logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  input  logic                              beat_valid,
  input  logic                              beat_avail,
  output logic                              run,
  output logic [LOG_MAX_ITERS-1:0]          iter_idx,
  output logic                              iter_done,
  output logic                              done,
  output logic                              err
);

  seq_state_e                        state;
  seq_state_e                        state_next;
  logic [LOG_MAX_READS_PER_ITER-1:0] read_cnt;
  logic [LOG_MAX_ITERS-1:0]          iter_cnt;
  logic                              beat;
  logic                              last_read;
  logic                              last_iter;
  logic                              zero_job;

  assign beat      = beat_valid & beat_avail;
  // Compare against latched-minus-one; zero counts never reach RUN, so no underflow.
  assign last_read = (read_cnt == num_reads_per_iter - LOG_MAX_READS_PER_ITER'(1));
  assign last_iter = (iter_cnt == num_iters - LOG_MAX_ITERS'(1));
  assign zero_job  = (num_iters == '0) || (num_reads_per_iter == '0);

  always_comb begin
    // NOTE: default assigned first so every path writes state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      ST_IDLE:   if (start) state_next = ST_CONFIG;
      ST_CONFIG: state_next = zero_job ? ST_DONE : ST_RUN;
      ST_RUN:    if (beat && last_read && last_iter) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_iters          <= '0;
      num_reads_per_iter <= '0;
      read_cnt           <= '0;
      iter_cnt           <= '0;
      err                <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        num_iters          <= job_iters;
        num_reads_per_iter <= job_reads;
        read_cnt           <= '0;
        iter_cnt           <= '0;
        err                <= beat;
      end else if (beat) begin
        err <= 1'b1;
      end
    end else if (state == ST_RUN) begin
      if (beat) begin
        if (last_read) begin
          read_cnt <= '0;
          if (!last_iter) iter_cnt <= iter_cnt + LOG_MAX_ITERS'(1);
        end else begin
          read_cnt <= read_cnt + LOG_MAX_READS_PER_ITER'(1);
        end
      end
    end else if (beat) begin
      err <= 1'b1;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign configure = (state == ST_CONFIG);
  assign run       = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign iter_idx  = iter_cnt;
  assign iter_done = (state == ST_RUN) && beat && last_read;

endmodule

// File: tb/tb_align_ctrl.sv
// Bench for align_ctrl: per-cycle comparison against a beat-counting job
// model, plus directed jobs with hand-computed cycle numbers.
module tb_align_ctrl;

  localparam int IW = 16;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] job_iters;
  logic [RW-1:0] job_reads;
  logic          busy;
  logic          configure;
  logic [IW-1:0] num_iters;
  logic [RW-1:0] num_reads_per_iter;
  logic          beat_valid;
  logic          beat_avail;
  logic          run;
  logic [IW-1:0] iter_idx;
  logic          iter_done;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  align_ctrl #(.LOG_MAX_ITERS(IW), .LOG_MAX_READS_PER_ITER(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .job_iters(job_iters),
    .job_reads(job_reads), .busy(busy), .configure(configure),
    .num_iters(num_iters), .num_reads_per_iter(num_reads_per_iter),
    .beat_valid(beat_valid), .beat_avail(beat_avail), .run(run),
    .iter_idx(iter_idx), .iter_done(iter_done), .done(done), .err(err)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Job model: phase 0 idle, 1 config, 2 run, 3 done; progress is a total beat count.
  int     m_phase;
  longint m_iters, m_reads, m_beats;
  bit     m_err;

  always @(posedge clk) begin
    bit b;
    b = beat_valid & beat_avail;
    if (rst) begin
      m_phase = 0; m_iters = 0; m_reads = 0; m_beats = 0; m_err = 0;
    end else begin
      case (m_phase)
        0: begin
          if (start) begin
            m_iters = job_iters; m_reads = job_reads; m_beats = 0;
            m_err = b; m_phase = 1;
          end else if (b) m_err = 1;
        end
        1: begin
          if (b) m_err = 1;
          m_phase = (m_iters == 0 || m_reads == 0) ? 3 : 2;
        end
        2: if (b) begin
          m_beats++;
          if (m_beats == m_iters * m_reads) m_phase = 3;
        end
        default: begin
          if (b) m_err = 1;
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    longint ei;
    bit     eid;
    if (cmp_en) begin
      if (m_iters == 0 || m_reads == 0) ei = 0;
      else ei = (m_beats / m_reads < m_iters - 1) ? m_beats / m_reads : m_iters - 1;
      eid = (m_phase == 2) && beat_valid && beat_avail && (m_reads != 0) &&
            ((m_beats + 1) % m_reads == 0);
      check("busy",      busy,      m_phase != 0);
      check("configure", configure, m_phase == 1);
      check("run",       run,       m_phase == 2);
      check("done",      done,      m_phase == 3);
      check("iter_done", iter_done, eid);
      check("iter_idx",  iter_idx,  ei);
      check("num_iters", num_iters, m_iters);
      check("num_reads", num_reads_per_iter, m_reads);
      check("err",       err,       m_err);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Runs one job; cycle 1 is the cycle after the start edge.
  task automatic run_job(input int it, input int rd, input bit toggle, input int inject_at,
                         input int rst_after, output int cfg_cyc, output int done_cyc,
                         output int pulses, output int beats, output bit run_seen);
    start = 1'b1; job_iters = IW'(it); job_reads = RW'(rd);
    beat_valid = 1'b0; beat_avail = 1'b0;
    step();
    start = 1'b0;
    cfg_cyc = -1; done_cyc = -1; pulses = 0; beats = 0; run_seen = 1'b0;
    for (int cyc = 1; cyc <= 70000; cyc++) begin
      start = (cyc == inject_at);
      if (start) begin job_iters = IW'(7); job_reads = RW'(9); end
      if (rst_after > 0 && beats == rst_after) begin
        rst = 1'b1; beat_valid = 1'b0; beat_avail = 1'b0;
        step();
        rst = 1'b0;
        return;
      end
      beat_valid = run;
      beat_avail = toggle ? (cyc % 2 == 1) : 1'b1;
      #1;
      if (configure && cfg_cyc < 0) cfg_cyc = cyc;
      if (run) run_seen = 1'b1;
      if (iter_done) pulses++;
      if (beat_valid && beat_avail && run) beats++;
      if (done) begin done_cyc = cyc; break; end
      step();
    end
    start = 1'b0; beat_valid = 1'b0; beat_avail = 1'b0;
    if (done_cyc < 0) check("job_timeout", done, 1'b1);
    step();
  endtask

  initial begin
    int cfg, dn, pl, bt;
    bit rs;
    rst = 1'b1; start = 1'b0; job_iters = '0; job_reads = '0;
    beat_valid = 1'b0; beat_avail = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_num_iters", num_iters, 0);

    // 2x3, beats every cycle
    run_job(2, 3, 1'b0, 0, 0, cfg, dn, pl, bt, rs);
    check("t1_cfg_cycle", cfg, 1);
    check("t1_done_cycle", dn, 8);
    check("t1_pulses", pl, 2);
    check("t1_beats", bt, 6);
    check("t1_iter_idx_final", iter_idx, 1);
    check("t1_idle", busy, 0);

    // 2x3, avail toggling
    run_job(2, 3, 1'b1, 0, 0, cfg, dn, pl, bt, rs);
    check("t2_done_cycle", dn, 14);
    check("t2_pulses", pl, 2);
    check("t2_beats", bt, 6);

    // zero-iteration job
    run_job(0, 5, 1'b0, 0, 0, cfg, dn, pl, bt, rs);
    check("t3_cfg_cycle", cfg, 1);
    check("t3_done_cycle", dn, 2);
    check("t3_run_seen", rs, 0);
    check("t3_num_reads", num_reads_per_iter, 5);

    // start during RUN is ignored
    run_job(2, 3, 1'b0, 3, 0, cfg, dn, pl, bt, rs);
    check("t4_done_cycle", dn, 8);
    check("t4_num_iters", num_iters, 2);
    check("t4_num_reads", num_reads_per_iter, 3);

    // stray beat in IDLE sets sticky err; next start clears it
    beat_valid = 1'b1; beat_avail = 1'b1;
    step();
    beat_valid = 1'b0; beat_avail = 1'b0;
    check("t5_err_set", err, 1);
    repeat (3) step();
    check("t5_err_held", err, 1);
    run_job(1, 2, 1'b0, 0, 0, cfg, dn, pl, bt, rs);
    check("t5_err_cleared", err, 0);
    check("t5_done_cycle", dn, 4);

    // reset after 2 beats, then a fresh job
    run_job(2, 3, 1'b0, 0, 2, cfg, dn, pl, bt, rs);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_run", run, 0);
    check("t6_num_iters", num_iters, 0);
    check("t6_iter_idx", iter_idx, 0);
    step();
    check("t6_no_done", done, 0);
    run_job(2, 3, 1'b0, 0, 0, cfg, dn, pl, bt, rs);
    check("t6_fresh_done_cycle", dn, 8);

    // maximum reads per iteration
    run_job(1, 65535, 1'b0, 0, 0, cfg, dn, pl, bt, rs);
    check("t7_beats", bt, 65535);
    check("t7_done_cycle", dn, 65537);
    check("t7_pulses", pl, 1);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
